// File: rtl/kp_pkg.sv
// Shared types and helpers for the keypad encoder: FSM state encoding,
// bit positions in the conditioned input vector and priority helpers.
package kp_pkg;

    localparam int KP_W    = 18;
    localparam int KP_BKSP = 16;
    localparam int KP_CLR  = 17;

    typedef enum logic [1:0] {
        IDLE,
        STABLE,
        ACCEPT,
        HELD
    } kp_state_t;

    // Highest-numbered pressed hex key wins when several are held together.
    function automatic logic [3:0] kp_top_key(input logic [15:0] keys);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (keys[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Only a lone hex key or a lone backspace may auto-repeat; clear never does.
    function automatic logic kp_can_repeat(input logic [KP_W-1:0] pat);
        logic lone_hex;
        logic lone_bksp;
        lone_hex  = $onehot(pat[15:0]) && !pat[KP_BKSP];
        lone_bksp = (pat[15:0] == 16'h0000) && pat[KP_BKSP];
        return !pat[KP_CLR] && (lone_hex || lone_bksp);
    endfunction

endpackage

// File: rtl/kp_debounce.sv
// Two-flop synchronizer plus a free-running run-length counter on the
// synchronized sample; reports when the sample is stably pressed or released.
module kp_debounce
    import kp_pkg::*;
#(
    parameter int DEBOUNCE = 5
) (
    input  logic            hz100,
    input  logic            reset,
    input  logic [KP_W-1:0] raw,
    output logic [KP_W-1:0] sample,
    output logic            stable,
    output logic            released,
    output logic            ready
);

    logic [KP_W-1:0] sync1_q, sync1_d;
    logic [KP_W-1:0] sync2_q, sync2_d;
    logic [KP_W-1:0] last_q, last_d;
    logic [7:0]      run_q, run_d;
    logic [1:0]      fill_q, fill_d;
    logic            ready_q, ready_d;
    logic            run_met;

    // run_d counts how many further samples have matched the first one of the
    // current run, so DEBOUNCE identical samples means run_d == DEBOUNCE-1.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        last_d  = sync2_q;
        run_d   = 8'd0;
        if (sync2_q == last_q) begin
            run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
        end
        fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        // Keys held through reset must not count as a fresh press: arm only
        // after a genuine all-released sample has come through the pipeline.
        ready_d = ready_q | ((fill_q == 2'd2) && (sync2_q == '0));
        run_met = ({1'b0, run_d} >= 9'(DEBOUNCE - 1));
    end

    assign sample   = sync2_q;
    assign stable   = (sync2_q != '0) && run_met;
    assign released = (sync2_q == '0) && run_met;
    assign ready    = ready_q;

    always_ff @(posedge hz100) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            last_q  <= '0;
            run_q   <= '0;
            fill_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            last_q  <= last_d;
            run_q   <= run_d;
            fill_q  <= fill_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// Debounced hex keypad encoder with a shifting entry register of DIGITS nibbles.
// Optional auto-repeat of held keys is enabled by defining KP_AUTOREPEAT_EN.
module keypad_encoder
    import kp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DEBOUNCE = 5,
    parameter int REPEAT   = 50
) (
    input  logic                  hz100,
    input  logic                  reset,
    input  logic [15:0]           keys,
    input  logic                  bksp,
    input  logic                  clr,
    output logic [3:0]            code,
    output logic                  strobe,
    output logic [4*DIGITS-1:0]   entry,
    output logic [DIGITS-1:0]     digit_en,
    output logic [3:0]            count
);

    localparam int ENTRY_W = 4 * DIGITS;

    if (DIGITS < 1 || DIGITS > 8 || DEBOUNCE < 1 || DEBOUNCE > 255 ||
        REPEAT < 2 || REPEAT > 255) begin : g_param_check
        $error("keypad_encoder: parameter out of range");
    end

    logic [KP_W-1:0] sample;
    logic            stable;
    logic            released;
    logic            ready;

    kp_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .hz100    (hz100),
        .reset    (reset),
        .raw      ({clr, bksp, keys}),
        .sample   (sample),
        .stable   (stable),
        .released (released),
        .ready    (ready)
    );

    kp_state_t           state_q, state_d;
    logic [KP_W-1:0]     pat_q, pat_d;
    logic [3:0]          code_q, code_d;
    logic                strobe_q, strobe_d;
    logic [ENTRY_W-1:0]  entry_q, entry_d;
    logic [DIGITS-1:0]   digit_en_q, digit_en_d;
    logic [3:0]          count_q, count_d;

`ifdef KP_AUTOREPEAT_EN
    logic [7:0]          rpt_q, rpt_d;
    logic                rpt_on_q, rpt_on_d;
`endif

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        code_d     = code_q;
        strobe_d   = 1'b0;
        entry_d    = entry_q;
        digit_en_d = digit_en_q;
        count_d    = count_q;
`ifdef KP_AUTOREPEAT_EN
        rpt_d      = rpt_q;
        rpt_on_d   = rpt_on_q;
`endif
        case (state_q)
            IDLE: begin
                if (ready && sample != '0) begin
                    pat_d   = sample;
                    state_d = stable ? ACCEPT : STABLE;
                end
            end
            STABLE: begin
                if (sample == '0) begin
                    state_d = IDLE;
                end else begin
                    pat_d = sample;
                    if (stable) begin
                        state_d = ACCEPT;
                    end
                end
            end
            ACCEPT: begin
                // Priority: clear, then highest hex key, then backspace.
                if (pat_q[KP_CLR]) begin
                    entry_d    = '0;
                    digit_en_d = '0;
                    count_d    = '0;
                end else if (pat_q[15:0] != 16'h0000) begin
                    code_d     = kp_top_key(pat_q[15:0]);
                    strobe_d   = 1'b1;
                    entry_d    = ENTRY_W'({entry_q, code_d});
                    digit_en_d = DIGITS'({digit_en_q, 1'b1});
                    count_d    = (count_q >= 4'(DIGITS)) ? 4'(DIGITS) : count_q + 4'd1;
                end else if (pat_q[KP_BKSP]) begin
                    entry_d    = entry_q >> 4;
                    digit_en_d = digit_en_q >> 1;
                    count_d    = (count_q == 4'd0) ? 4'd0 : count_q - 4'd1;
                end
`ifdef KP_AUTOREPEAT_EN
                rpt_d    = '0;
                rpt_on_d = kp_can_repeat(pat_q);
`endif
                state_d = HELD;
            end
            HELD: begin
`ifdef KP_AUTOREPEAT_EN
                if (released) begin
                    state_d  = IDLE;
                    rpt_on_d = 1'b0;
                end else if (sample != pat_q) begin
                    rpt_on_d = 1'b0;
                end else if (rpt_on_q) begin
                    rpt_d = rpt_q + 8'd1;
                    if ({1'b0, rpt_q} + 9'd1 == 9'(REPEAT - 1)) begin
                        state_d = ACCEPT;
                    end
                end
`else
                if (released) begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            code_q     <= '0;
            strobe_q   <= 1'b0;
            entry_q    <= '0;
            digit_en_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            code_q     <= code_d;
            strobe_q   <= strobe_d;
            entry_q    <= entry_d;
            digit_en_q <= digit_en_d;
            count_q    <= count_d;
        end
    end

`ifdef KP_AUTOREPEAT_EN
    always_ff @(posedge hz100) begin
        if (reset) begin
            rpt_q    <= '0;
            rpt_on_q <= 1'b0;
        end else begin
            rpt_q    <= rpt_d;
            rpt_on_q <= rpt_on_d;
        end
    end
`endif

    assign code     = code_q;
    assign strobe   = strobe_q;
    assign entry    = entry_q;
    assign digit_en = digit_en_q;
    assign count    = count_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed self-checking bench for keypad_encoder (DIGITS=4, DEBOUNCE=5, REPEAT=50).
// Exercises the KP_AUTOREPEAT_EN variant when that macro is defined.
module tb_keypad_encoder;

    localparam int DIGITS   = 4;
    localparam int DEBOUNCE = 5;
    localparam int REPEAT   = 50;

    logic        hz100 = 1'b0;
    logic        reset;
    logic [15:0] keys;
    logic        bksp;
    logic        clr;
    logic [3:0]  code;
    logic        strobe;
    logic [15:0] entry;
    logic [3:0]  digit_en;
    logic [3:0]  count;

    keypad_encoder #(
        .DIGITS   (DIGITS),
        .DEBOUNCE (DEBOUNCE),
        .REPEAT   (REPEAT)
    ) dut (
        .hz100    (hz100),
        .reset    (reset),
        .keys     (keys),
        .bksp     (bksp),
        .clr      (clr),
        .code     (code),
        .strobe   (strobe),
        .entry    (entry),
        .digit_en (digit_en),
        .count    (count)
    );

    always #5 hz100 = ~hz100;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   strobe_total = 0;
    int   back_to_back = 0;
    int   last_strobe_cyc = -1;
    logic prev_strobe = 1'b0;
    int   strobe_cycs[$];

    always @(posedge hz100) cyc++;

    // Strobe monitor samples on the falling edge, away from the active edge.
    always @(negedge hz100) begin
        if (strobe === 1'b1) begin
            strobe_total++;
            if (prev_strobe) back_to_back++;
            last_strobe_cyc = cyc;
            strobe_cycs.push_back(cyc);
        end
        prev_strobe = (strobe === 1'b1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] k, input logic b, input logic c);
        @(negedge hz100);
        keys = k;
        bksp = b;
        clr  = c;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge hz100);
    endtask

    task automatic pressAndRelease(input logic [15:0] k, input logic b, input logic c,
                                   input int hold, output int press_cyc);
        applyStimulus(k, b, c);
        press_cyc = cyc;
        waitCycles(hold);
        applyStimulus(16'h0000, 1'b0, 1'b0);
        waitCycles(12);
    endtask

    int pc;
    int s0;
    int qi;

    initial begin
        reset = 1'b1;
        keys  = 16'h0000;
        bksp  = 1'b0;
        clr   = 1'b0;
        waitCycles(3);
        checkOutput("rst_code", 32'(code), 32'h0);
        checkOutput("rst_strobe", 32'(strobe), 32'h0);
        checkOutput("rst_entry", 32'(entry), 32'h0);
        checkOutput("rst_digit_en", 32'(digit_en), 32'h0);
        checkOutput("rst_count", 32'(count), 32'h0);
        reset = 1'b0;
        waitCycles(5);

        $display("[TB] clean press of key A");
        s0 = strobe_total;
        pressAndRelease(16'h0400, 1'b0, 1'b0, 20, pc);
        checkOutput("a_latency", 32'(last_strobe_cyc - pc), 32'd8);
        checkOutput("a_strobes", 32'(strobe_total - s0), 32'd1);
        checkOutput("a_code", 32'(code), 32'hA);
        checkOutput("a_entry", 32'(entry), 32'h000A);
        checkOutput("a_count", 32'(count), 32'd1);
        checkOutput("a_digit_en", 32'(digit_en), 32'b0001);

        $display("[TB] sequence 1..5 overflows the entry register");
        s0 = strobe_total;
        for (int d = 1; d <= 5; d++) begin
            pressAndRelease(16'(1 << d), 1'b0, 1'b0, 8, pc);
        end
        checkOutput("seq_strobes", 32'(strobe_total - s0), 32'd5);
        checkOutput("seq_entry", 32'(entry), 32'h2345);
        checkOutput("seq_count", 32'(count), 32'd4);
        checkOutput("seq_digit_en", 32'(digit_en), 32'b1111);
        checkOutput("seq_code", 32'(code), 32'h5);

        $display("[TB] bouncing key 3");
        s0 = strobe_total;
        for (int t = 0; t < 32; t++) begin
            applyStimulus(((t / 2) % 2 == 0) ? 16'h0008 : 16'h0000, 1'b0, 1'b0);
        end
        checkOutput("bounce_quiet", 32'(strobe_total - s0), 32'd0);
        pressAndRelease(16'h0008, 1'b0, 1'b0, 15, pc);
        checkOutput("bounce_strobes", 32'(strobe_total - s0), 32'd1);
        checkOutput("bounce_latency", 32'(last_strobe_cyc - pc), 32'd8);
        checkOutput("bounce_code", 32'(code), 32'h3);
        checkOutput("bounce_entry", 32'(entry), 32'h3453);

        $display("[TB] backspace down to empty");
        pressAndRelease(16'h0000, 1'b0, 1'b1, 10, pc);
        checkOutput("clr1_entry", 32'(entry), 32'h0);
        pressAndRelease(16'h0002, 1'b0, 1'b0, 10, pc);
        pressAndRelease(16'h0004, 1'b0, 1'b0, 10, pc);
        checkOutput("pre_bksp_entry", 32'(entry), 32'h0012);
        s0 = strobe_total;
        pressAndRelease(16'h0000, 1'b1, 1'b0, 10, pc);
        checkOutput("bksp1_entry", 32'(entry), 32'h0001);
        checkOutput("bksp1_count", 32'(count), 32'd1);
        pressAndRelease(16'h0000, 1'b1, 1'b0, 10, pc);
        checkOutput("bksp2_entry", 32'(entry), 32'h0000);
        checkOutput("bksp2_digit_en", 32'(digit_en), 32'b0000);
        pressAndRelease(16'h0000, 1'b1, 1'b0, 10, pc);
        checkOutput("bksp3_count", 32'(count), 32'd0);
        checkOutput("bksp3_entry", 32'(entry), 32'h0000);
        checkOutput("bksp_strobes", 32'(strobe_total - s0), 32'd0);
        checkOutput("bksp_code", 32'(code), 32'h2);

        $display("[TB] two keys together, then clear");
        s0 = strobe_total;
        pressAndRelease(16'h0204, 1'b0, 1'b0, 10, pc);
        checkOutput("dual_strobes", 32'(strobe_total - s0), 32'd1);
        checkOutput("dual_code", 32'(code), 32'h9);
        checkOutput("dual_entry", 32'(entry), 32'h0009);
        pressAndRelease(16'h0000, 1'b0, 1'b1, 10, pc);
        checkOutput("clr2_entry", 32'(entry), 32'h0);
        checkOutput("clr2_count", 32'(count), 32'd0);
        checkOutput("clr2_digit_en", 32'(digit_en), 32'b0000);
        checkOutput("clr2_code", 32'(code), 32'h9);

        $display("[TB] action priority");
        pressAndRelease(16'h0010, 1'b0, 1'b0, 10, pc);
        s0 = strobe_total;
        pressAndRelease(16'h0020, 1'b0, 1'b1, 10, pc);
        checkOutput("clr_wins_strobes", 32'(strobe_total - s0), 32'd0);
        checkOutput("clr_wins_entry", 32'(entry), 32'h0);
        checkOutput("clr_wins_code", 32'(code), 32'h4);
        pressAndRelease(16'h0010, 1'b0, 1'b0, 10, pc);
        pressAndRelease(16'h0002, 1'b1, 1'b0, 10, pc);
        checkOutput("key_over_bksp_entry", 32'(entry), 32'h0041);
        checkOutput("key_over_bksp_code", 32'(code), 32'h1);
        checkOutput("key_over_bksp_count", 32'(count), 32'd2);

        $display("[TB] reset while key 7 is held");
        applyStimulus(16'h0080, 1'b0, 1'b0);
        waitCycles(12);
        checkOutput("pre_rst_entry", 32'(entry), 32'h0417);
        @(negedge hz100);
        reset = 1'b1;
        @(negedge hz100);
        reset = 1'b0;
        checkOutput("mid_rst_entry", 32'(entry), 32'h0);
        checkOutput("mid_rst_count", 32'(count), 32'd0);
        checkOutput("mid_rst_code", 32'(code), 32'h0);
        checkOutput("mid_rst_digit_en", 32'(digit_en), 32'b0000);
        s0 = strobe_total;
        waitCycles(20);
        checkOutput("held_after_rst", 32'(strobe_total - s0), 32'd0);
        applyStimulus(16'h0000, 1'b0, 1'b0);
        waitCycles(12);
        pressAndRelease(16'h0080, 1'b0, 1'b0, 10, pc);
        checkOutput("repress_strobes", 32'(strobe_total - s0), 32'd1);
        checkOutput("repress_entry", 32'(entry), 32'h0007);

        $display("[TB] long hold of key 6");
        s0 = strobe_total;
        qi = strobe_cycs.size();
        pressAndRelease(16'h0040, 1'b0, 1'b0, 200, pc);
`ifdef KP_AUTOREPEAT_EN
        checkOutput("rpt_strobes", 32'(strobe_total - s0), 32'd4);
        checkOutput("rpt_entry", 32'(entry), 32'h6666);
        checkOutput("rpt_seen", 32'(strobe_cycs.size()), 32'(qi + 4));
        if (strobe_cycs.size() >= qi + 4) begin
            checkOutput("rpt_first", 32'(strobe_cycs[qi] - pc), 32'd8);
            for (int i = 1; i <= 3; i++) begin
                checkOutput("rpt_gap", 32'(strobe_cycs[qi + i] - strobe_cycs[qi]), 32'(REPEAT * i));
            end
        end
`else
        checkOutput("hold_strobes", 32'(strobe_total - s0), 32'd1);
        checkOutput("hold_entry", 32'(entry), 32'h0076);
        checkOutput("hold_count", 32'(count), 32'd2);
`endif

        checkOutput("no_back_to_back", 32'(back_to_back), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
